onewire_txn_sequencer: RTL and testbench

- Transaction-level controller for the 1-wire bus; sits above a bit-level 1-wire engine that owns the open-drain port and all slot timing.
- Arbitrates round-robin between NREQ requesters and sequences one full transaction per grant: reset/presence, ROM command byte, function command byte, then 0..MAX_RD read bytes.
- Returns read data and a completion status to the granted requester.
- Never touches the wire directly.

---
 rtl/onewire_pkg.sv | 24 ++
 rtl/onewire_rr_arbiter.sv | 60 ++++++
 rtl/onewire_txn_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_onewire_txn_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-wire transaction sequencer.
// Holds the bit-engine op encodings, completion status codes and the sequencer state type.
package onewire_pkg;

    // Bit-engine operations driven on be_op
    localparam logic [1:0] BE_RESET = 2'b00;
    localparam logic [1:0] BE_WRITE = 2'b01;
    localparam logic [1:0] BE_READ  = 2'b10;

    // Completion status reported with done
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NOPRES  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StWrRom,
        StWrFn,
        StRd,
        StDone
    } state_e;

endpackage

// File: rtl/onewire_rr_arbiter.sv
// Round-robin requester pick for the 1-wire sequencer.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   req          : per-requester request levels
//   take         : strobe, the current pick is being granted (owner is latched)
//   free         : strobe, the owner releases; pointer moves to owner + 1 mod NREQ
//   pick         : one-hot first requester at or after the pointer (combinational)
//   pick_idx     : binary index of pick
//   any          : at least one request pending
module onewire_rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic                      take,
    input  logic                      free,
    output logic [NREQ-1:0]           pick,
    output logic [$clog2(NREQ)-1:0]   pick_idx,
    output logic                      any
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] owner_q;
    logic          found;
    int            j;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = (int'(ptr_q) + k) % int'(NREQ);
            if (!found && req[j]) begin
                found    = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = PW'(j);
            end
        end
        any = |req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            if (take) begin
                owner_q <= pick_idx;
            end
            if (free) begin
                ptr_q <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/onewire_txn_sequencer.sv
// Transaction-level 1-wire controller above a bit-level engine.
// Grants one requester at a time (round-robin) and runs reset/presence, ROM command byte,
// function command byte and 0..MAX_RD read bytes through the be_* handshake.
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   req, req_rom_cmd, req_fn_cmd,
//   req_rd_len                         : per-requester request and transaction parameters
//   gnt, busy, done, status            : grant and completion reporting
//   rd_data, rd_valid, rd_last         : received bytes
//   be_req, be_op, be_wbit             : bit-engine command
//   be_ack, be_rbit, be_presence       : bit-engine response
module onewire_txn_sequencer
    import onewire_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MAX_RD  = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_rom_cmd,
    input  logic [NREQ*8-1:0] req_fn_cmd,
    input  logic [NREQ*4-1:0] req_rd_len,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              be_req,
    output logic [1:0]        be_op,
    output logic              be_wbit,
    input  logic              be_ack,
    input  logic              be_rbit,
    input  logic              be_presence
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned LW = $clog2(MAX_RD + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, pick;
    logic [PW-1:0]   pick_idx;
    logic            any_req;
    logic [7:0]      rom_q, fn_q, sr_q, rd_data_q;
    logic [LW-1:0]   len_q, byte_cnt_q, len_sel;
    logic [3:0]      len_raw;
    logic [2:0]      bit_cnt_q;
    logic [TW-1:0]   tmo_q;
    logic            be_req_q, rd_valid_q, rd_last_q;
    logic [1:0]      status_q;
    logic            grant, issuing, ack_ok, tmo_hit, bit7, last_byte, byte_end;
    int              sel;

    onewire_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .take     (grant),
        .free     (state_q == StDone),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any_req)
    );

    always_comb begin
        sel       = int'(pick_idx);
        len_raw   = req_rd_len[sel*4 +: 4];
        len_sel   = (32'(len_raw) > MAX_RD) ? LW'(MAX_RD) : LW'(len_raw);
        grant     = (state_q == StIdle) && any_req;
        issuing   = state_q inside {StRst, StWrRom, StWrFn, StRd};
        // An ack only counts while a bit is actually outstanding; ack wins over a same-cycle timeout
        ack_ok    = be_ack && be_req_q;
        tmo_hit   = be_req_q && !be_ack && (tmo_q == TMO_LAST);
        bit7      = (bit_cnt_q == 3'd7);
        last_byte = (byte_cnt_q == len_q - LW'(1));
        byte_end  = ack_ok && (state_q == StRd) && bit7;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StRst;
            StRst: begin
                if (tmo_hit) state_d = StDone;
                else if (ack_ok) state_d = be_presence ? StWrRom : StDone;
            end
            StWrRom: begin
                if (tmo_hit) state_d = StDone;
                else if (ack_ok && bit7) state_d = StWrFn;
            end
            StWrFn: begin
                if (tmo_hit) state_d = StDone;
                else if (ack_ok && bit7) state_d = (len_q == '0) ? StDone : StRd;
            end
            StRd: begin
                if (tmo_hit) state_d = StDone;
                else if (byte_end && last_byte) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q      <= '0;
            rom_q      <= '0;
            fn_q       <= '0;
            len_q      <= '0;
            sr_q       <= '0;
            rd_data_q  <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            be_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            status_q   <= ST_OK;
        end else begin
            if (grant) begin
                gnt_q      <= pick;
                rom_q      <= req_rom_cmd[sel*8 +: 8];
                fn_q       <= req_fn_cmd[sel*8 +: 8];
                len_q      <= len_sel;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                status_q   <= ST_OK;
            end else if (state_q == StDone) begin
                gnt_q <= '0;
            end

            // Low for one cycle between bits: any issuing cycle with be_req low raises it
            if (ack_ok || tmo_hit) begin
                be_req_q <= 1'b0;
            end else if (issuing && !be_req_q) begin
                be_req_q <= 1'b1;
            end

            if (issuing && !be_req_q) begin
                tmo_q <= '0;
            end else if (be_req_q) begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (ack_ok && (state_q != StRst)) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (ack_ok && (state_q == StRd)) begin
                sr_q <= {be_rbit, sr_q[7:1]};
            end

            rd_valid_q <= byte_end;
            rd_last_q  <= byte_end && last_byte;
            if (byte_end) begin
                rd_data_q  <= {be_rbit, sr_q[7:1]};
                byte_cnt_q <= byte_cnt_q + LW'(1);
            end

            if (ack_ok && (state_q == StRst) && !be_presence) begin
                status_q <= ST_NOPRES;
            end
            if (tmo_hit) begin
                status_q <= ST_TIMEOUT;
            end
        end
    end

    // Outputs
    always_comb begin
        gnt      = gnt_q;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        status   = status_q;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        rd_last  = rd_last_q;
        be_req   = be_req_q;
        be_op    = BE_RESET;
        be_wbit  = 1'b0;
        case (state_q)
            StWrRom: begin
                be_op   = BE_WRITE;
                be_wbit = rom_q[bit_cnt_q];
            end
            StWrFn: begin
                be_op   = BE_WRITE;
                be_wbit = fn_q[bit_cnt_q];
            end
            StRd:    be_op = BE_READ;
            default: be_op = BE_RESET;
        endcase
    end

endmodule

// File: tb/tb_onewire_txn_sequencer.sv
// Directed bench for onewire_txn_sequencer with a behavioural bit-engine model.
module tb_onewire_txn_sequencer;

    logic        clk, reset;
    logic [1:0]  req;
    logic [15:0] req_rom_cmd, req_fn_cmd;
    logic [7:0]  req_rd_len;
    logic [1:0]  gnt;
    logic        busy, done, rd_valid, rd_last, be_req, be_wbit;
    logic [1:0]  status, be_op;
    logic [7:0]  rd_data;
    logic        be_ack, be_rbit, be_presence;

    onewire_txn_sequencer #(
        .NREQ    (2),
        .MAX_RD  (8),
        .TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_rom_cmd (req_rom_cmd),
        .req_fn_cmd  (req_fn_cmd),
        .req_rd_len  (req_rd_len),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .be_req      (be_req),
        .be_op       (be_op),
        .be_wbit     (be_wbit),
        .be_ack      (be_ack),
        .be_rbit     (be_rbit),
        .be_presence (be_presence)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-engine model state and logs
    logic       eng_presence = 1'b1;
    logic [7:0] eng_bytes[8];
    int         withhold_op = -1;
    int         hi_cnt = 0;
    int         op_count = 0, rst_count = 0, wr_count = 0, rd_bits = 0;
    logic [1:0] op_log[128];
    logic [63:0] wlog;

    // Monitor logs
    int         rv_count = 0, done_cnt = 0, run = 0, last_run = 0;
    logic [7:0] rv_data[16];
    logic       rv_last[16];

    initial begin
        be_ack = 1'b0;
        be_rbit = 1'b0;
        be_presence = 1'b0;
        forever begin
            @(negedge clk);
            if (be_ack) begin
                be_ack = 1'b0;
                hi_cnt = 0;
            end else if (be_req) begin
                hi_cnt++;
                if (hi_cnt == 2 && op_count != withhold_op) begin
                    be_ack = 1'b1;
                    be_presence = eng_presence;
                    be_rbit = 1'b0;
                    if (op_count < 128) op_log[op_count] = be_op;
                    case (be_op)
                        2'b00: rst_count++;
                        2'b01: begin
                            if (wr_count < 64) wlog[wr_count] = be_wbit;
                            wr_count++;
                        end
                        2'b10: begin
                            be_rbit = eng_bytes[(rd_bits / 8) % 8][rd_bits % 8];
                            rd_bits++;
                        end
                        default: ;
                    endcase
                    op_count++;
                end
            end else begin
                hi_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (rv_count < 16) begin
                    rv_data[rv_count] = rd_data;
                    rv_last[rv_count] = rd_last;
                end
                rv_count++;
            end
            if (done) done_cnt++;
            if (be_req) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        op_count = 0; rst_count = 0; wr_count = 0; rd_bits = 0;
        rv_count = 0; wlog = '0; last_run = 0;
    endtask

    task automatic wait_done(input int budget);
        int  start;
        logic got;
        start = done_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_busy();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("busy_seen", 32'(got), 32'd1);
    endtask

    // Launch requester 0 then scramble its inputs to show the latched copy is used
    task automatic run_req0(input logic [7:0] rom, input logic [7:0] fn, input logic [3:0] len,
                            input int budget);
        clear_logs();
        req_rom_cmd[7:0] = rom;
        req_fn_cmd[7:0]  = fn;
        req_rd_len[3:0]  = len;
        req = 2'b01;
        wait_busy();
        req = 2'b00;
        req_rom_cmd[7:0] = 8'hFF;
        req_fn_cmd[7:0]  = 8'h00;
        req_rd_len[3:0]  = 4'd5;
        wait_done(budget);
    endtask

    logic [1:0] exp_gnt[3];
    int         dc;

    initial begin
        reset = 1'b0;
        req = '0;
        req_rom_cmd = '0;
        req_fn_cmd = '0;
        req_rd_len = '0;
        wlog = '0;
        for (int i = 0; i < 8; i++) eng_bytes[i] = 8'h00;
        repeat (3) tick();
        check_eq("reset_outputs", 32'({gnt, busy, done, status, rd_data, rd_valid, rd_last,
                                       be_req, be_op, be_wbit}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Both requesters held: grants alternate starting from pointer 0
        req_rom_cmd = {8'h33, 8'hCC};
        req_fn_cmd  = {8'h44, 8'hBE};
        req_rd_len  = {4'd0, 4'd1};
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
        req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            wait_done(2000);
            check_eq($sformatf("rr_gnt%0d", t), 32'(gnt), 32'(exp_gnt[t]));
            check_eq($sformatf("rr_status%0d", t), 32'(status), 32'd0);
            if (t == 2) req = 2'b00;
            tick();
            check_eq($sformatf("rr_idle_gap%0d", t), 32'({busy, gnt}), 32'd0);
        end

        // Main transaction: CC / BE, two read bytes
        eng_presence = 1'b1;
        eng_bytes[0] = 8'h5A;
        eng_bytes[1] = 8'hA5;
        run_req0(8'hCC, 8'hBE, 4'd2, 2000);
        check_eq("a_gnt", 32'(gnt), 32'h1);
        check_eq("a_status", 32'(status), 32'd0);
        check_eq("a_wbits", 32'(wlog[15:0]), 32'hBECC);
        check_eq("a_counts", {8'(rst_count), 8'(wr_count), 8'(rd_bits), 8'(rv_count)},
                 {8'd1, 8'd16, 8'd16, 8'd2});
        check_eq("a_op_order", {30'd0, op_log[0]}, 32'd0);
        check_eq("a_op_rd", {30'd0, op_log[17]}, 32'd2);
        check_eq("a_byte0", {23'd0, rv_last[0], rv_data[0]}, 32'h05A);
        check_eq("a_byte1", {23'd0, rv_last[1], rv_data[1]}, 32'h1A5);
        tick();
        check_eq("a_release", 32'({busy, done, gnt}), 32'd0);

        // No presence: single reset op, no writes
        eng_presence = 1'b0;
        run_req0(8'hCC, 8'hBE, 4'd2, 500);
        check_eq("np_status", 32'(status), 32'd1);
        check_eq("np_ops", {8'(op_count), 8'(rst_count), 8'(wr_count), 8'(rd_bits)},
                 {8'd1, 8'd1, 8'd0, 8'd0});
        eng_presence = 1'b1;
        tick();

        // Ack withheld on the third ROM bit (op index 3)
        withhold_op = 3;
        run_req0(8'hCC, 8'hBE, 4'd0, 500);
        check_eq("to_status", 32'(status), 32'd2);
        check_eq("to_req_len", 32'(last_run), 32'd100);
        check_eq("to_be_req_low", 32'(be_req), 32'd0);
        check_eq("to_writes", 32'(wr_count), 32'd2);
        withhold_op = -1;
        tick();

        // Zero-length read: 16 writes then done
        run_req0(8'hCC, 8'hBE, 4'd0, 1000);
        check_eq("z_status", 32'(status), 32'd0);
        check_eq("z_counts", {8'(wr_count), 8'(rd_bits), 8'(rv_count)}, {8'd16, 8'd0, 8'd0});
        check_eq("z_wbits", 32'(wlog[15:0]), 32'hBECC);
        tick();

        // rd_len 15 clamps to 8 bytes
        for (int i = 0; i < 8; i++) eng_bytes[i] = 8'(8'h11 * (i + 1));
        run_req0(8'h55, 8'h0F, 4'd15, 3000);
        check_eq("cl_rv_count", 32'(rv_count), 32'd8);
        check_eq("cl_rd_bits", 32'(rd_bits), 32'd64);
        check_eq("cl_byte7", {23'd0, rv_last[7], rv_data[7]}, 32'h188);
        check_eq("cl_byte6", {23'd0, rv_last[6], rv_data[6]}, 32'h077);
        check_eq("cl_status", 32'(status), 32'd0);
        tick();

        // Reset asserted while reading byte 1
        eng_bytes[0] = 8'h5A;
        eng_bytes[1] = 8'hA5;
        clear_logs();
        req_rom_cmd[7:0] = 8'hCC;
        req_fn_cmd[7:0]  = 8'hBE;
        req_rd_len[3:0]  = 4'd2;
        req = 2'b01;
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (rv_count == 1) begin
                    got = 1'b1;
                    break;
                end
            end
            check_eq("rs_byte0_seen", 32'(got), 32'd1);
        end
        repeat (3) tick();
        dc = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        check_eq("rs_async_outputs", 32'({gnt, busy, done, status, rd_data, rd_valid, rd_last,
                                          be_req, be_op, be_wbit}), 32'd0);
        repeat (3) tick();
        check_eq("rs_no_done", 32'(done_cnt), 32'(dc));
        clear_logs();
        @(negedge clk);
        reset = 1'b1;
        wait_done(2000);
        req = 2'b00;
        check_eq("rs_restart_first_op", {30'd0, op_log[0]}, 32'd0);
        check_eq("rs_restart", {8'(rst_count), 8'(wr_count), 8'(rv_count), 6'd0, status},
                 {8'd1, 8'd16, 8'd2, 8'd0});
        check_eq("rs_gnt", 32'(gnt), 32'h1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
